// File: rtl/sync_ram_master.sv
// Host-side controller for a single-port synchronous RAM with a shared tri-state data bus.
// Optional build macro SYNC_RAM_MASTER_RANGE_CHECK_EN rejects addresses >= DEPTH without touching the RAM.
module sync_ram_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("sync_ram_master: DEPTH must lie in 1..2**ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic                  req_ready_n;
    logic                  rsp_valid_n;
    logic                  rsp_we_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_n;
    logic                  rsp_err_n;
    logic                  ram_cs_n;
    logic                  ram_we_n;
    logic                  ram_oe_n;
    logic [ADDR_WIDTH-1:0] ram_addr_n;
    logic                  addr_err;

`ifdef SYNC_RAM_MASTER_RANGE_CHECK_EN
    assign addr_err = ({1'b0, req_addr} >= DEPTH[ADDR_WIDTH:0]);
`else
    assign addr_err = 1'b0;
`endif

    // The RAM only drives while ram_we is low, so handing the bus over needs no idle cycle.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
        end else begin
            state     <= state_n;
            wdata_q   <= wdata_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_we    <= rsp_we_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            ram_cs    <= ram_cs_n;
            ram_we    <= ram_we_n;
            ram_oe    <= ram_oe_n;
            ram_addr  <= ram_addr_n;
        end
    end

    // Next-state logic also computes the next value of every registered output,
    // so the RAM pins for a state are already valid throughout that state.
    always_comb begin
        state_n     = state;
        wdata_n     = wdata_q;
        req_ready_n = req_ready;
        rsp_valid_n = rsp_valid;
        rsp_we_n    = rsp_we;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        ram_cs_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_oe_n    = 1'b0;
        ram_addr_n  = ram_addr;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    wdata_n     = req_wdata;
                    ram_addr_n  = req_addr;
                    req_ready_n = 1'b0;
                    rsp_we_n    = req_we;
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b0;
                    if (addr_err) begin
                        state_n     = RSP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else if (req_we) begin
                        state_n  = WR;
                        ram_cs_n = 1'b1;
                        ram_we_n = 1'b1;
                    end else begin
                        state_n  = RD_ADDR;
                        ram_cs_n = 1'b1;
                    end
                end
            end
            WR: begin
                state_n     = RSP;
                rsp_valid_n = 1'b1;
            end
            RD_ADDR: begin
                state_n  = RD_DATA;
                ram_cs_n = 1'b1;
                ram_oe_n = 1'b1;
            end
            RD_DATA: begin
                state_n     = RSP;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = ram_data;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

endmodule
